wd_interleave_mapper: RTL and testbench
=======================================

Name: wd_interleave_mapper

Overview:
- Parametrised successor to the WD sector-order engine. Builds a full physical-slot to sector-ID map for one track, then streams it in physical order over a valid/ready interface.
- Feeds the format/write-back path, and handles cases the previous generation did not: non-coprime interleave (slip to the next free slot), track skew, and a programmable first sector ID.
- Sits between the WD command FSM and the track-buffer DMA.

Parameters:
- MAX_SECTORS, 64, maximum sectors per track (ESDI/RLL headroom).
- INT_W, 5, interleave field width (interleave 1-31).
- ID_W, 8, sector ID width.
- Derived localparams: SEC_W = clog2(MAX_SECTORS+1) for counts; SLOT_W = clog2(MAX_SECTORS) for indices.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches the config below
- abort  in  1  cancels a build or stream in progress
- sectors_per_track  in  SEC_W  N
- interleave  in  INT_W  I (1 = sequential)
- skew  in  SLOT_W  physical slot holding logical sector 0
- first_sector_id  in  ID_W  ID base (0 or 1 typical)
- busy  out  1  high from start until done/abort
- done  out  1  one-cycle completion pulse
- cfg_error  out  1  one-cycle pulse on illegal config
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer accepts
- out_slot  out  SLOT_W  physical slot, 0..N-1
- out_sector  out  ID_W  first_sector_id + logical index
- out_last  out  1  asserted with slot N-1
- build_cycles  out  SEC_W+1  cycles used by the last BUILD (diagnostic)

Behaviour:
- Reset state: IDLE; every output and all internal state 0; occupancy bitmap cleared.
- States: IDLE, CHECK, CLEAR, BUILD, STREAM, FIN.
- IDLE:
  - start latches the config and goes to CHECK.
  - start is ignored while busy.
- CHECK (1 cycle): the config is illegal if N==0, N>MAX_SECTORS, I==0, I>=N with N>1, or skew>=N.
  - Illegal: pulse cfg_error and done together, go to IDLE; out_valid never asserts.
  - Legal: go to CLEAR.
- CLEAR: zeroes the occupancy bitmap, 1 cycle (vector clear).
- BUILD:
  - Start state: pos=skew, k=0.
  - Each cycle, if occ[pos] is set: pos=pos+1, wrapping at N.
  - Otherwise: map[pos]=k, occ[pos]=1, k=k+1, pos=pos+I, wrapping by subtracting N when the sum is >= N (sum < 2N, so one subtract is enough).
  - Exits when k==N. build_cycles = N + collisions.
  - N==1 with I==1 is legal; the map is a single entry.
- STREAM:
  - out_slot starts at 0 and out_valid is registered high.
  - out_sector = first_sector_id + map[out_slot], truncated modulo 2^ID_W.
  - On out_valid&&out_ready, advance the slot.
  - While out_valid&&!out_ready, out_slot, out_sector and out_last hold stable.
  - The handshake with out_last=1 goes to FIN, with out_valid low on the next cycle.
- FIN: pulses done for 1 cycle, drops busy, returns to IDLE.
- Latency: start to first out_valid = 3 + build_cycles clocks.
- Throughput: one sector per clock under continuous out_ready.
- abort:
  - Honoured in any non-IDLE state; takes priority over a simultaneous handshake.
  - Next cycle: IDLE, out_valid=0, busy=0, no done pulse.
- start coincident with abort: abort wins and start is dropped.
- The map contents are undefined outside STREAM.
- Asynchronous reset mid-operation restores the reset state.

Optional Feature:
- Macro: WD_INTERLEAVE_INVERSE_EN.
- Defined:
  - BUILD also writes inv[k]=pos.
  - Adds ports lookup_req (in, 1), lookup_index (in, SLOT_W), lookup_slot (out, SLOT_W) and lookup_valid (out, 1).
  - lookup_slot and lookup_valid are registered 1 cycle after lookup_req, and are valid only in STREAM or IDLE after a successful build.
  - A lookup outside those states, or with lookup_index>=N, returns lookup_valid=0.
  - Used by the read path for rotational seek prediction.
- Undefined: the inverse table and the lookup ports are absent.

Decomposition:
- Package wd_hdd_pkg: MAX_SECTORS default, state encoding enum, ID-base constants (WD_ID_BASE0/1), cfg-error cause codes.
- Sub-module wd_interleave_map_ram:
  - Holds the occupancy bitmap, the map array (and the inverse array when enabled).
  - Ports: clear, write port (addr, data) and an async read port for occ/map.

Test Plan:
- N=17, I=3, skew=0, base=1 -> stream 1,7,13,2,8,14,3,...; build_cycles=17; out_last with slot 16; done pulse 1 cycle after the last handshake.
- N=18, I=2, skew=0, base=1 (non-coprime) -> one collision; build_cycles=19; stream 1,10,2,11,3,12,...,9,18.
- N=17, I=1, skew=5, base=1 -> stream 13,14,15,16,17,1,2,...,12.
- N=26, I=4, out_ready low for 5 cycles at slot 4 -> out_slot/out_sector stable throughout; total handshakes = 26; no duplicate or missing IDs (scoreboard).
- Configs N=0; I=0; I=17 with N=17; skew=20 with N=17 -> cfg_error and done pulse together, out_valid stays 0, busy high exactly 1 cycle after start.
- Abort at slot 7 of STREAM, then restart with a new config -> no done for the aborted run, clean full second stream; reset_n asserted mid-BUILD -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/wd_hdd_pkg.sv
// rtl/wd_hdd_pkg.sv - shared types, constants and config check for the WD interleave mapper
package wd_hdd_pkg;

  localparam int WD_MAX_SECTORS = 64;
  localparam int WD_ID_BASE0    = 0;
  localparam int WD_ID_BASE1    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CLEAR,
    ST_BUILD,
    ST_STREAM,
    ST_FIN
  } wd_state_e;

  typedef enum logic [2:0] {
    CFG_OK,
    CFG_ZERO_N,
    CFG_BIG_N,
    CFG_ZERO_I,
    CFG_BIG_I,
    CFG_BAD_SKEW
  } cfg_cause_e;

  // I >= N is only harmful when there is more than one slot to visit.
  function automatic cfg_cause_e cfg_check(int unsigned n, int unsigned il,
                                           int unsigned skew, int unsigned max_n);
    if (n == 0) return CFG_ZERO_N;
    if (n > max_n) return CFG_BIG_N;
    if (il == 0) return CFG_ZERO_I;
    if (il >= n && n > 1) return CFG_BIG_I;
    if (skew >= n) return CFG_BAD_SKEW;
    return CFG_OK;
  endfunction

endpackage

// File: rtl/wd_interleave_mapper_if.sv
// rtl/wd_interleave_mapper_if.sv - physical-order sector stream between mapper and track-buffer DMA
interface wd_interleave_mapper_if #(
  parameter int SLOT_W = 6,
  parameter int ID_W   = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [SLOT_W-1:0] out_slot;
  logic [ID_W-1:0]   out_sector;
  logic              out_last;

  modport master (output out_valid, out_slot, out_sector, out_last, input out_ready);
  modport slave  (input out_valid, out_slot, out_sector, out_last, output out_ready);
endinterface

// File: rtl/wd_interleave_map_ram.sv
// rtl/wd_interleave_map_ram.sv - occupancy bitmap and slot map storage; WD_INTERLEAVE_INVERSE_EN adds the inverse table
module wd_interleave_map_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_occ,
  output logic [AW-1:0] rd_map
`ifdef WD_INTERLEAVE_INVERSE_EN
  ,
  input  logic [AW-1:0] inv_rd_addr,
  output logic [AW-1:0] inv_rd_data
`endif
);

  logic [DEPTH-1:0] occ;
  logic [AW-1:0]    map_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) map_mem[i] <= '0;
    end else begin
      if (clear) occ <= '0;
      else if (wr_en) occ[wr_addr] <= 1'b1;
      if (wr_en) map_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_occ = occ[rd_addr];
  assign rd_map = map_mem[rd_addr];

`ifdef WD_INTERLEAVE_INVERSE_EN
  logic [AW-1:0] inv_mem [DEPTH];

  // Same write port, transposed: logical index -> physical slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) inv_mem[i] <= '0;
    end else if (wr_en) begin
      inv_mem[wr_data] <= wr_addr;
    end
  end

  assign inv_rd_data = inv_mem[inv_rd_addr];
`endif

endmodule

// File: rtl/wd_interleave_mapper.sv
// rtl/wd_interleave_mapper.sv - builds a track interleave map and streams it in slot order; WD_INTERLEAVE_INVERSE_EN adds an ID-to-slot lookup
module wd_interleave_mapper
  import wd_hdd_pkg::*;
#(
  parameter  int MAX_SECTORS = WD_MAX_SECTORS,
  parameter  int INT_W       = 5,
  parameter  int ID_W        = 8,
  localparam int SEC_W       = $clog2(MAX_SECTORS + 1),
  localparam int SLOT_W      = $clog2(MAX_SECTORS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SEC_W-1:0]       sectors_per_track,
  input  logic [INT_W-1:0]       interleave,
  input  logic [SLOT_W-1:0]      skew,
  input  logic [ID_W-1:0]        first_sector_id,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error,
  wd_interleave_mapper_if.master out_if,
  output logic [SEC_W:0]         build_cycles
`ifdef WD_INTERLEAVE_INVERSE_EN
  ,
  input  logic                   lookup_req,
  input  logic [SLOT_W-1:0]      lookup_index,
  output logic [SLOT_W-1:0]      lookup_slot,
  output logic                   lookup_valid
`endif
);

  wd_state_e         state;
  logic [SEC_W-1:0]  n_q;
  logic [INT_W-1:0]  il_q;
  logic [SLOT_W-1:0] skew_q;
  logic [ID_W-1:0]   base_q;
  logic [SLOT_W-1:0] pos, k, slot;
  logic [SEC_W:0]    bcnt;
  logic              valid_q, last_q;

  logic              rd_occ, wr_en, ram_clear, cfg_ok;
  logic [SLOT_W-1:0] rd_addr, rd_map, pos_slip, pos_jump;
  logic [SEC_W-1:0]  pos_inc, k_next;
  logic [SEC_W:0]    jump_sum, jump_wrap;
`ifdef WD_INTERLEAVE_INVERSE_EN
  logic [SLOT_W-1:0] inv_slot;
  logic              built_q, lookup_ok;
`endif

  // The jump never exceeds 2N because a legal I is below N, so one subtract wraps it.
  always_comb begin
    pos_inc   = SEC_W'(pos) + SEC_W'(1);
    pos_slip  = (pos_inc == n_q) ? '0 : SLOT_W'(pos_inc);
    jump_sum  = (SEC_W+1)'(pos) + (SEC_W+1)'(il_q);
    jump_wrap = (jump_sum >= (SEC_W+1)'(n_q)) ? jump_sum - (SEC_W+1)'(n_q) : jump_sum;
    pos_jump  = SLOT_W'(jump_wrap);
    k_next    = SEC_W'(k) + SEC_W'(1);
    cfg_ok    = (cfg_check(32'(n_q), 32'(il_q), 32'(skew_q), MAX_SECTORS) == CFG_OK);
  end

  assign rd_addr   = (state == ST_BUILD) ? pos : slot;
  assign wr_en     = (state == ST_BUILD) && !rd_occ;
  assign ram_clear = (state == ST_CLEAR);

  wd_interleave_map_ram #(.DEPTH(MAX_SECTORS), .AW(SLOT_W)) u_ram (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (ram_clear),
    .wr_en       (wr_en),
    .wr_addr     (pos),
    .wr_data     (k),
    .rd_addr     (rd_addr),
    .rd_occ      (rd_occ),
    .rd_map      (rd_map)
`ifdef WD_INTERLEAVE_INVERSE_EN
    ,
    .inv_rd_addr (lookup_index),
    .inv_rd_data (inv_slot)
`endif
  );

  assign out_if.out_valid  = valid_q;
  assign out_if.out_slot   = slot;
  assign out_if.out_last   = last_q;
  assign out_if.out_sector = (state == ST_STREAM) ? base_q + ID_W'(rd_map) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      n_q          <= '0;
      il_q         <= '0;
      skew_q       <= '0;
      base_q       <= '0;
      pos          <= '0;
      k            <= '0;
      slot         <= '0;
      bcnt         <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_error    <= 1'b0;
      build_cycles <= '0;
    end else begin
      done      <= 1'b0;
      cfg_error <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        slot    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              n_q    <= sectors_per_track;
              il_q   <= interleave;
              skew_q <= skew;
              base_q <= first_sector_id;
              busy   <= 1'b1;
              state  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (cfg_ok) begin
              state <= ST_CLEAR;
            end else begin
              cfg_error <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          ST_CLEAR: begin
            pos   <= skew_q;
            k     <= '0;
            bcnt  <= '0;
            state <= ST_BUILD;
          end
          ST_BUILD: begin
            bcnt <= bcnt + 1'b1;
            if (rd_occ) begin
              pos <= pos_slip;
            end else begin
              k   <= k + 1'b1;
              pos <= pos_jump;
              if (k_next == n_q) begin
                build_cycles <= bcnt + 1'b1;
                slot         <= '0;
                valid_q      <= 1'b1;
                last_q       <= (n_q == SEC_W'(1));
                state        <= ST_STREAM;
              end
            end
          end
          ST_STREAM: begin
            if (out_if.out_ready) begin
              if (last_q) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                slot    <= '0;
                done    <= 1'b1;
                busy    <= 1'b0;
                state   <= ST_FIN;
              end else begin
                slot   <= slot + 1'b1;
                last_q <= (SEC_W'(slot) + SEC_W'(2) == n_q);
              end
            end
          end
          ST_FIN:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef WD_INTERLEAVE_INVERSE_EN
  assign lookup_ok = lookup_req && (SEC_W'(lookup_index) < n_q) &&
                     (state == ST_STREAM || (state == ST_IDLE && built_q));

  // STREAM is only reachable through a completed build, so it marks the table good.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      built_q      <= 1'b0;
      lookup_valid <= 1'b0;
      lookup_slot  <= '0;
    end else begin
      if (state == ST_IDLE && start && !abort) built_q <= 1'b0;
      else if (state == ST_STREAM) built_q <= 1'b1;
      lookup_valid <= lookup_ok;
      lookup_slot  <= lookup_ok ? inv_slot : '0;
    end
  end
`endif

endmodule

// File: tb/tb_wd_interleave_mapper.sv
// tb/tb_wd_interleave_mapper.sv - self-checking bench for wd_interleave_mapper (WD_INTERLEAVE_INVERSE_EN optional)
module tb_wd_interleave_mapper;
  import wd_hdd_pkg::*;

  localparam int MAXS   = 64;
  localparam int INT_W  = 5;
  localparam int ID_W   = 8;
  localparam int SEC_W  = $clog2(MAXS + 1);
  localparam int SLOT_W = $clog2(MAXS);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SEC_W-1:0]  sectors_per_track = '0;
  logic [INT_W-1:0]  interleave = '0;
  logic [SLOT_W-1:0] skew = '0;
  logic [ID_W-1:0]   first_sector_id = '0;
  logic              busy, done, cfg_error;
  logic [SEC_W:0]    build_cycles;
`ifdef WD_INTERLEAVE_INVERSE_EN
  logic              lookup_req = 1'b0;
  logic [SLOT_W-1:0] lookup_index = '0;
  logic [SLOT_W-1:0] lookup_slot;
  logic              lookup_valid;
`endif

  wd_interleave_mapper_if #(.SLOT_W(SLOT_W), .ID_W(ID_W)) sif ();

  wd_interleave_mapper #(.MAX_SECTORS(MAXS), .INT_W(INT_W), .ID_W(ID_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .sectors_per_track (sectors_per_track),
    .interleave        (interleave),
    .skew              (skew),
    .first_sector_id   (first_sector_id),
    .busy              (busy),
    .done              (done),
    .cfg_error         (cfg_error),
    .out_if            (sif),
    .build_cycles      (build_cycles)
`ifdef WD_INTERLEAVE_INVERSE_EN
    ,
    .lookup_req        (lookup_req),
    .lookup_index      (lookup_index),
    .lookup_slot       (lookup_slot),
    .lookup_valid      (lookup_valid)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_map [64];
  int exp_inv [64];
  int exp_bc;
  int got [64];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference placement: for each logical index, slide forward past taken slots, then jump by I.
  function automatic void model(input int n, input int il, input int sk);
    bit taken [64];
    int p;
    foreach (taken[j]) taken[j] = 1'b0;
    p = sk;
    exp_bc = n;
    for (int lk = 0; lk < n; lk++) begin
      while (taken[p]) begin
        p = (p + 1) % n;
        exp_bc++;
      end
      exp_map[p] = lk;
      exp_inv[lk] = p;
      taken[p] = 1'b1;
      p = (p + il) % n;
    end
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 stall 5 cycles at slot 4 (with an ignored start)
  task automatic run(input int n, input int il, input int sk, input int base,
                     input int ready_mode, input int abort_at);
    int cyc, hs, hold, d0, bad, idx;
    int seen [64];
    bit rdy;
    model(n, il, sk);
    @(negedge clk);
    sectors_per_track = SEC_W'(n);
    interleave        = INT_W'(il);
    skew              = SLOT_W'(sk);
    first_sector_id   = ID_W'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (sif.out_valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 3 + exp_bc);
    check("build_cycles", build_cycles, exp_bc);
    d0 = done_cnt;
    foreach (seen[j]) seen[j] = 0;
    hs = 0; hold = 0; cyc = 0;
    while (hs < n && cyc < 2000) begin
      check("valid", sif.out_valid, 1);
      check("slot", sif.out_slot, hs);
      check("sector", sif.out_sector, (base + exp_map[hs]) % 256);
      check("last", sif.out_last, hs == n - 1);
      got[hs] = int'(sif.out_sector);
      if (hs == abort_at) begin
        abort = 1'b1;
        sif.out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sif.out_ready = 1'b0;
        check("abort_valid", sif.out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(hs == 4 && hold < 5);
      endcase
      if (!rdy) hold++;
      start = (ready_mode == 2 && hs == 4 && hold == 1);
      if (start) sectors_per_track = SEC_W'(5);
      sif.out_ready = rdy;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (rdy) begin
        idx = (got[hs] - base + 256) % 256;
        if (idx < n) seen[idx]++;
        hs++;
      end
    end
    sif.out_ready = 1'b0;
    check("handshakes", hs, n);
    check("fin_valid", sif.out_valid, 0);
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt, d0 + 1);
    bad = 0;
    for (int j = 0; j < n; j++) if (seen[j] != 1) bad++;
    check("scoreboard_ids", bad, 0);
  endtask

  task automatic run_bad(input string tag, input int n, input int il, input int sk);
    @(negedge clk);
    sectors_per_track = SEC_W'(n);
    interleave        = INT_W'(il);
    skew              = SLOT_W'(sk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_check"}, busy, 1);
    check({tag, "_no_err_yet"}, cfg_error, 0);
    @(negedge clk);
    check({tag, "_cfg_error"}, cfg_error, 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_valid"}, sif.out_valid, 0);
    @(negedge clk);
    check({tag, "_cfg_error_pulse"}, cfg_error, 0);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_valid_after"}, sif.out_valid, 0);
  endtask

  initial begin
    int rn, ril, rsk, rbase;
    sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_error", cfg_error, 0);
    check("rst_valid", sif.out_valid, 0);
    check("rst_slot", sif.out_slot, 0);
    check("rst_sector", sif.out_sector, 0);
    check("rst_last", sif.out_last, 0);
    check("rst_build_cycles", build_cycles, 0);
    reset_n = 1'b1;

    run(17, 3, 0, WD_ID_BASE1, 0, -1);
    check("t1_bc", build_cycles, 17);
    check("t1_s1", got[1], 7);
    check("t1_s2", got[2], 13);
    check("t1_s3", got[3], 2);
`ifdef WD_INTERLEAVE_INVERSE_EN
    for (int j = 0; j < 19; j += 3) begin
      @(negedge clk);
      lookup_req = 1'b1;
      lookup_index = SLOT_W'(j);
      @(negedge clk);
      lookup_req = 1'b0;
      check("lookup_valid", lookup_valid, j < 17);
      check("lookup_slot", lookup_slot, (j < 17) ? exp_inv[j] : 0);
    end
`endif

    run(18, 2, 0, WD_ID_BASE1, 1, -1);
    check("t2_bc", build_cycles, 19);
    check("t2_s1", got[1], 10);
    check("t2_s17", got[17], 18);

    run(17, 1, 5, WD_ID_BASE1, 0, -1);
    check("t3_s0", got[0], 13);
    check("t3_s5", got[5], 1);
    check("t3_s16", got[16], 12);

    run(26, 4, 0, WD_ID_BASE0, 2, -1);
    run(1, 1, 0, 200, 1, -1);
    run(40, 7, 9, 250, 1, -1);

    run_bad("n0", 0, 3, 0);
    run_bad("i0", 17, 0, 0);
    run_bad("i17", 17, 17, 0);
    run_bad("skew20", 17, 3, 20);
    run_bad("n65", 65, 3, 0);

    run(20, 3, 2, 1, 1, 7);
    run(23, 5, 4, 0, 1, -1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    @(negedge clk);
    check("start_abort_valid", sif.out_valid, 0);
    check("start_abort_busy2", busy, 0);

    for (int t = 0; t < 6; t++) begin
      rn    = int'($urandom_range(1, 64));
      ril   = (rn == 1) ? 1 : int'($urandom_range(1, (rn - 1 < 31) ? rn - 1 : 31));
      rsk   = int'($urandom_range(0, rn - 1));
      rbase = int'($urandom_range(0, 255));
      run(rn, ril, rsk, rbase, 1, -1);
    end

    @(negedge clk);
    sectors_per_track = SEC_W'(40);
    interleave        = INT_W'(3);
    skew              = SLOT_W'(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cfg_error", cfg_error, 0);
    check("mid_rst_valid", sif.out_valid, 0);
    check("mid_rst_slot", sif.out_slot, 0);
    check("mid_rst_sector", sif.out_sector, 0);
    check("mid_rst_last", sif.out_last, 0);
    check("mid_rst_build_cycles", build_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(12, 5, 3, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
